// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and main memory.
// The master side drives requests and the memory return line; the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [LINE_W-1:0] mem_rdata;

    logic              i_gnt;
    logic              d_gnt;
    logic              i_valid;
    logic              d_valid;
    logic [LINE_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              stall;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, d_gnt, i_valid, d_valid, rdata, mem_en, mem_we,
               mem_addr, mem_wdata, stall
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, d_gnt, i_valid, d_valid, rdata, mem_en, mem_we,
               mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data misses onto one fixed-latency main memory port.
// Ties go to the side not granted last; each transfer runs IDLE -> BUSY (MEM_LAT cycles) -> RESP.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int LINE_W  = 128
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;   // 1 = data side owns the transfer
    logic              last_q, last_d;     // 1 = data side was granted last
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic any_req;
    logic pick_d;
    logic busy;
    logic resp;

    assign any_req = bus.i_req | bus.d_req;
    assign pick_d  = bus.d_req & (~bus.i_req | ~last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick_d;
                    last_d  = pick_d;
                    // Line-align at capture so later address changes cannot leak in
                    addr_d  = (pick_d ? bus.d_addr : bus.i_addr) & 32'hFFFF_FFF0;
                    we_d    = pick_d & bus.d_we;
                    wdata_d = bus.d_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    assign bus.i_gnt     = (busy | resp) & ~owner_q;
    assign bus.d_gnt     = (busy | resp) & owner_q;
    assign bus.i_valid   = resp & ~owner_q;
    assign bus.d_valid   = resp & owner_q;
    assign bus.mem_en    = busy;
    assign bus.mem_we    = busy & we_q;
    assign bus.mem_addr  = busy ? addr_q : 32'd0;
    assign bus.mem_wdata = busy ? wdata_q : 32'd0;
    assign bus.rdata     = rdata_q;
    // Reset gating keeps stall low while a held request meets an asserted reset
    assign bus.stall     = rst & (busy | ((state_q == IDLE) & any_req));
endmodule
